// File: rtl/hazard_ctl_pkg.sv
// Shared definitions for the hazard controller and the lu_match comparator.
// State encodings are fixed because debug tooling decodes the raw state bits.
package hazard_defs;

   localparam int HZ_REG_W = 3;
   localparam int HZ_CNT_W = 16;

   typedef enum logic [1:0] {
      HZ_IDLE     = 2'd0,
      HZ_LU_HOLD  = 2'd1,
      HZ_MEM_WAIT = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_ctl_lu_match.sv
// Load-use comparator: flags a decode-stage read of a register that a load in EX
// is about to write. Kept separate so the forwarding unit can reuse it.
module lu_match #(
   parameter int REG_W = 3
) (
   input  logic [REG_W-1:0] rs,
   input  logic             rs_vld,
   input  logic [REG_W-1:0] rt,
   input  logic             rt_vld,
   input  logic             mem_en,
   input  logic             mem_wr,
   input  logic [REG_W-1:0] rd,
   input  logic             rd_vld,
   output logic             lu_hit
);

   logic is_load;
   logic src_hit;

   // r0 is an ordinary register here, so no zero-register exclusion.
   assign is_load = mem_en & ~mem_wr & rd_vld;
   assign src_hit = (rs_vld & (rs == rd)) | (rt_vld & (rt == rd));
   assign lu_hit  = is_load & src_hit;

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: load-use bubbles, memory-wait freezes and
// taken-branch flushes, plus a saturating count of PC-stall cycles.
module hazard_ctl
   import hazard_defs::*;
#(
   parameter int REG_W  = HZ_REG_W,
   parameter int LU_CYC = 1,
   parameter int CNT_W  = HZ_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] if_id_rs,
   input  logic             if_id_rs_vld,
   input  logic [REG_W-1:0] if_id_rt,
   input  logic             if_id_rt_vld,
   input  logic             id_ex_mem_en,
   input  logic             id_ex_mem_wr,
   input  logic [REG_W-1:0] id_ex_rd,
   input  logic             id_ex_rd_vld,
   input  logic             mem_req,
   input  logic             mem_done,
   input  logic             br_taken,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic             pipe_freeze,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [2:0]       LU_RELOAD = 3'(LU_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   hz_state_e        state_q, state_d;
   logic [2:0]       bub_q, bub_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic lu_hit;
   logic freeze_req;
   logic pc_stall_c, if_id_stall_c, id_ex_bubble_c, if_id_flush_c, pipe_freeze_c;

   lu_match #(.REG_W(REG_W)) u_lu_match (
      .rs     (if_id_rs),
      .rs_vld (if_id_rs_vld),
      .rt     (if_id_rt),
      .rt_vld (if_id_rt_vld),
      .mem_en (id_ex_mem_en),
      .mem_wr (id_ex_mem_wr),
      .rd     (id_ex_rd),
      .rd_vld (id_ex_rd_vld),
      .lu_hit (lu_hit)
   );

   assign freeze_req = mem_req & ~mem_done;

   always_comb begin
      state_d        = state_q;
      bub_d          = bub_q;
      pc_stall_c     = 1'b0;
      if_id_stall_c  = 1'b0;
      id_ex_bubble_c = 1'b0;
      if_id_flush_c  = 1'b0;
      pipe_freeze_c  = 1'b0;

      case (state_q)
         HZ_IDLE: begin
            if (freeze_req) begin
               pipe_freeze_c = 1'b1;
               pc_stall_c    = 1'b1;
               if_id_stall_c = 1'b1;
               state_d       = HZ_MEM_WAIT;
            end else if (br_taken) begin
               // Squashing the consumer makes any concurrent load-use hit moot.
               if_id_flush_c  = 1'b1;
               id_ex_bubble_c = 1'b1;
            end else if (lu_hit) begin
               pc_stall_c     = 1'b1;
               if_id_stall_c  = 1'b1;
               id_ex_bubble_c = 1'b1;
               if (LU_CYC > 1) begin
                  bub_d   = LU_RELOAD;
                  state_d = HZ_LU_HOLD;
               end
            end
         end
         HZ_LU_HOLD: begin
            if (freeze_req) begin
               // Freeze holds EX too, so a pending branch waits; bub is kept.
               pipe_freeze_c = 1'b1;
               pc_stall_c    = 1'b1;
               if_id_stall_c = 1'b1;
               state_d       = HZ_MEM_WAIT;
            end else if (br_taken) begin
               if_id_flush_c  = 1'b1;
               id_ex_bubble_c = 1'b1;
               bub_d          = 3'd0;
               state_d        = HZ_IDLE;
            end else begin
               pc_stall_c     = 1'b1;
               if_id_stall_c  = 1'b1;
               id_ex_bubble_c = 1'b1;
               bub_d          = bub_q - 3'd1;
               if (bub_q == 3'd1) state_d = HZ_IDLE;
            end
         end
         HZ_MEM_WAIT: begin
            if (mem_done) begin
               state_d = (bub_q != 3'd0) ? HZ_LU_HOLD : HZ_IDLE;
            end else begin
               pipe_freeze_c = 1'b1;
               pc_stall_c    = 1'b1;
               if_id_stall_c = 1'b1;
            end
         end
         default: state_d = HZ_IDLE;
      endcase

      if (!rst) begin
         pc_stall_c     = 1'b0;
         if_id_stall_c  = 1'b0;
         id_ex_bubble_c = 1'b0;
         if_id_flush_c  = 1'b0;
         pipe_freeze_c  = 1'b0;
      end

      cnt_d = cnt_q;
      if (pc_stall_c && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= HZ_IDLE;
         bub_q   <= 3'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bub_q   <= bub_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_stall     = pc_stall_c;
   assign if_id_stall  = if_id_stall_c;
   assign id_ex_bubble = id_ex_bubble_c;
   assign if_id_flush  = if_id_flush_c;
   assign pipe_freeze  = pipe_freeze_c;
   assign stall_cnt    = rst ? cnt_q : '0;

endmodule

// File: tb/tb_hazard_ctl.sv
// Bench for hazard_ctl: two instances (LU_CYC=1/CNT_W=16 and LU_CYC=3/CNT_W=4)
// share stimulus and are both compared every cycle with a cycle-budget model.
module tb_hazard_ctl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [2:0] rs, rt, rd;
   logic       rs_vld, rt_vld, mem_en, mem_wr, rd_vld, mem_req, mem_done, br;

   logic        a_pc, a_ifid, a_bub, a_flush, a_frz;
   logic [15:0] a_cnt;
   logic        b_pc, b_ifid, b_bub, b_flush, b_frz;
   logic [3:0]  b_cnt;
   logic [4:0]  a_out, b_out;

   assign a_out = {a_frz, a_flush, a_bub, a_ifid, a_pc};
   assign b_out = {b_frz, b_flush, b_bub, b_ifid, b_pc};

   hazard_ctl #(.REG_W(3), .LU_CYC(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst),
      .if_id_rs(rs), .if_id_rs_vld(rs_vld), .if_id_rt(rt), .if_id_rt_vld(rt_vld),
      .id_ex_mem_en(mem_en), .id_ex_mem_wr(mem_wr), .id_ex_rd(rd), .id_ex_rd_vld(rd_vld),
      .mem_req(mem_req), .mem_done(mem_done), .br_taken(br),
      .pc_stall(a_pc), .if_id_stall(a_ifid), .id_ex_bubble(a_bub),
      .if_id_flush(a_flush), .pipe_freeze(a_frz), .stall_cnt(a_cnt)
   );

   hazard_ctl #(.REG_W(3), .LU_CYC(3), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst),
      .if_id_rs(rs), .if_id_rs_vld(rs_vld), .if_id_rt(rt), .if_id_rt_vld(rt_vld),
      .id_ex_mem_en(mem_en), .id_ex_mem_wr(mem_wr), .id_ex_rd(rd), .id_ex_rd_vld(rd_vld),
      .mem_req(mem_req), .mem_done(mem_done), .br_taken(br),
      .pc_stall(b_pc), .if_id_stall(b_ifid), .id_ex_bubble(b_bub),
      .if_id_flush(b_flush), .pipe_freeze(b_frz), .stall_cnt(b_cnt)
   );

   // Output vector order: {freeze, flush, bubble, if_id_stall, pc_stall}
   localparam logic [4:0] O_NONE  = 5'b00000;
   localparam logic [4:0] O_LU    = 5'b00111;
   localparam logic [4:0] O_FLUSH = 5'b01100;
   localparam logic [4:0] O_FRZ   = 5'b10011;

   typedef struct {
      logic       rst;
      logic [2:0] rs;
      logic       rs_vld;
      logic [2:0] rt;
      logic       rt_vld;
      logic       mem_en;
      logic       mem_wr;
      logic [2:0] rd;
      logic       rd_vld;
      logic       req;
      logic       done;
      logic       br;
      logic [4:0] exp_o;
      int         exp_c;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // Model: stall budget left, frozen flag, counter; per instance.
   int   m_left[2], n_left[2], m_cnt[2], n_cnt[2];
   bit   m_frz[2], n_frz[2];
   logic [4:0] m_out[2];
   int   m_luc[2] = '{1, 3};
   int   m_max[2] = '{65535, 15};

   function automatic vec_t mk(input logic r, input logic [2:0] s, input logic sv,
                               input logic [2:0] t, input logic tv, input logic me,
                               input logic mw, input logic [2:0] d, input logic dv,
                               input logic rq, input logic dn, input logic b,
                               input logic [4:0] eo, input int ec);
      vec_t v;
      v.rst = r; v.rs = s; v.rs_vld = sv; v.rt = t; v.rt_vld = tv;
      v.mem_en = me; v.mem_wr = mw; v.rd = d; v.rd_vld = dv;
      v.req = rq; v.done = dn; v.br = b; v.exp_o = eo; v.exp_c = ec;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_eval(input int i);
      bit hit;
      hit = mem_en && !mem_wr && rd_vld && ((rs_vld && rs == rd) || (rt_vld && rt == rd));
      n_left[i] = m_left[i];
      n_frz[i]  = m_frz[i];
      n_cnt[i]  = m_cnt[i];
      m_out[i]  = O_NONE;
      if (!rst) begin
         n_left[i] = 0;
         n_frz[i]  = 0;
         n_cnt[i]  = 0;
      end else begin
         if (m_frz[i]) begin
            if (mem_done) n_frz[i] = 0;
            else m_out[i] = O_FRZ;
         end else if (mem_req && !mem_done) begin
            m_out[i] = O_FRZ;
            n_frz[i] = 1;
         end else if (br) begin
            m_out[i]  = O_FLUSH;
            n_left[i] = 0;
         end else if (m_left[i] > 0) begin
            m_out[i]  = O_LU;
            n_left[i] = m_left[i] - 1;
         end else if (hit) begin
            m_out[i]  = O_LU;
            n_left[i] = m_luc[i] - 1;
         end
         if (m_out[i][0] && m_cnt[i] < m_max[i]) n_cnt[i] = m_cnt[i] + 1;
      end
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst; rs = v.rs; rs_vld = v.rs_vld; rt = v.rt; rt_vld = v.rt_vld;
      mem_en = v.mem_en; mem_wr = v.mem_wr; rd = v.rd; rd_vld = v.rd_vld;
      mem_req = v.req; mem_done = v.done; br = v.br;
   endtask

   task automatic settle();
      #1;
      model_eval(0);
      model_eval(1);
      chk("ref_a_out", 32'(a_out), 32'(m_out[0]));
      chk("ref_a_cnt", 32'(a_cnt), rst ? 32'(m_cnt[0]) : 32'd0);
      chk("ref_b_out", 32'(b_out), 32'(m_out[1]));
      chk("ref_b_cnt", 32'(b_cnt), rst ? 32'(m_cnt[1]) : 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         m_left[i] = n_left[i];
         m_frz[i]  = n_frz[i];
         m_cnt[i]  = n_cnt[i];
      end
      #1;
   endtask

   task automatic run(input vec_t v, input int sel, input string tag);
      drive(v);
      settle();
      if (sel == 0) begin
         chk({tag, "_out"}, 32'(a_out), 32'(v.exp_o));
         chk({tag, "_cnt"}, 32'(a_cnt), 32'(v.exp_c));
      end else begin
         chk({tag, "_out"}, 32'(b_out), 32'(v.exp_o));
         chk({tag, "_cnt"}, 32'(b_cnt), 32'(v.exp_c));
      end
      tick();
   endtask

   function automatic vec_t hit3(input logic rq, input logic dn, input logic b,
                                 input logic [4:0] eo, input int ec);
      return mk(1, 3, 1, 0, 0, 1, 0, 3, 1, rq, dn, b, eo, ec);
   endfunction

   function automatic vec_t idle(input logic rq, input logic dn, input logic b,
                                 input logic [4:0] eo, input int ec);
      return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, rq, dn, b, eo, ec);
   endfunction

   vec_t tbl[$];
   vec_t seq[$];

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_left[i] = 0; m_frz[i] = 0; m_cnt[i] = 0;
      end
      drive(idle(0, 0, 0, O_NONE, 0));
      rst = 1'b0;

      // LU_CYC=1 instance, table of single-cycle vectors
      tbl.push_back(mk(0, 3, 1, 0, 0, 1, 0, 3, 1, 1, 0, 1, O_NONE, 0));
      tbl.push_back(idle(0, 0, 0, O_NONE, 0));
      tbl.push_back(hit3(0, 0, 0, O_LU, 0));
      tbl.push_back(idle(0, 0, 0, O_NONE, 1));
      tbl.push_back(mk(1, 3, 0, 3, 0, 1, 0, 3, 1, 0, 0, 0, O_NONE, 1));
      tbl.push_back(mk(1, 3, 1, 3, 1, 1, 1, 3, 1, 0, 0, 0, O_NONE, 1));
      tbl.push_back(mk(1, 3, 1, 0, 0, 1, 0, 3, 0, 0, 0, 0, O_NONE, 1));
      tbl.push_back(mk(1, 2, 1, 5, 1, 1, 0, 5, 1, 0, 0, 0, O_LU, 1));
      tbl.push_back(mk(1, 2, 1, 5, 1, 1, 0, 5, 1, 0, 0, 1, O_FLUSH, 2));
      tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, O_LU, 2));
      tbl.push_back(idle(1, 1, 0, O_NONE, 3));
      tbl.push_back(hit3(1, 0, 1, O_FRZ, 3));
      tbl.push_back(hit3(1, 0, 1, O_FRZ, 4));
      tbl.push_back(hit3(1, 1, 1, O_NONE, 5));
      tbl.push_back(idle(0, 0, 1, O_FLUSH, 5));
      tbl.push_back(idle(0, 0, 0, O_NONE, 5));
      // 4-cycle memory wait with a branch held in EX throughout
      for (int k = 0; k < 4; k++) tbl.push_back(idle(1, 0, 1, O_FRZ, 5 + k));
      tbl.push_back(idle(1, 1, 1, O_NONE, 9));
      tbl.push_back(idle(0, 0, 1, O_FLUSH, 9));
      for (int k = 0; k < tbl.size(); k++) run(tbl[k], 0, $sformatf("tbl%0d", k));

      // LU_CYC=3 instance: plain run, branch mid-hold, freeze mid-hold
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0));
      seq.push_back(hit3(0, 0, 0, O_LU, 0));
      seq.push_back(hit3(0, 0, 0, O_LU, 1));
      seq.push_back(hit3(0, 0, 0, O_LU, 2));
      seq.push_back(idle(0, 0, 0, O_NONE, 3));
      seq.push_back(hit3(0, 0, 0, O_LU, 3));
      seq.push_back(hit3(0, 0, 0, O_LU, 4));
      seq.push_back(hit3(0, 0, 1, O_FLUSH, 5));
      seq.push_back(idle(0, 0, 0, O_NONE, 5));
      seq.push_back(hit3(0, 0, 0, O_LU, 5));
      seq.push_back(hit3(1, 0, 0, O_FRZ, 6));
      seq.push_back(hit3(1, 1, 0, O_NONE, 7));
      seq.push_back(hit3(0, 0, 0, O_LU, 7));
      seq.push_back(hit3(0, 0, 0, O_LU, 8));
      seq.push_back(idle(0, 0, 0, O_NONE, 9));
      // CNT_W=4 saturation, then reset in the middle of a memory wait
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0));
      for (int k = 0; k < 21; k++) seq.push_back(idle(1, 0, 0, O_FRZ, (k > 15) ? 15 : k));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_NONE, 0));
      seq.push_back(idle(0, 0, 0, O_NONE, 0));
      seq.push_back(hit3(0, 0, 0, O_LU, 0));
      for (int k = 0; k < seq.size(); k++) run(seq[k], 1, $sformatf("seqb%0d", k));

      // Random traffic; both instances against the model every cycle
      for (int k = 0; k < 800; k++) begin
         rst      = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
         rd       = 3'($urandom_range(0, 7));
         rs       = ($urandom_range(0, 1) == 1) ? rd : 3'($urandom_range(0, 7));
         rt       = ($urandom_range(0, 1) == 1) ? rd : 3'($urandom_range(0, 7));
         rs_vld   = 1'($urandom_range(0, 1));
         rt_vld   = 1'($urandom_range(0, 1));
         mem_en   = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
         mem_wr   = ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0;
         rd_vld   = ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0;
         mem_req  = ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0;
         mem_done = ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0;
         br       = ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0;
         settle();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
